// File: rtl/send_all_pkg.sv
// Shared constants and word packing for the inter-board link.
// Used by both the transmit (send_all) and receive sides.
package send_all_pkg;

  localparam int WORD_W    = 6;
  localparam int NUM_WORDS = 6;

  localparam int TYPE_W = 4;
  localparam int X_W    = 5;
  localparam int Y_W    = 3;
  localparam int CARD_W = 6;
  localparam int LEN_W  = 3;
  localparam int DIR_W  = 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_REL   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef struct packed {
    logic [TYPE_W-1:0] msg_type;
    logic [X_W-1:0]    block_x;
    logic [Y_W-1:0]    block_y;
    logic [CARD_W-1:0] card;
    logic [LEN_W-1:0]  sel_len;
    logic [DIR_W-1:0]  move_dir;
  } msg_t;

  // Zero-extended, LSB-aligned word for link slot idx.
  function automatic logic [WORD_W-1:0] pack_word(
    input logic [2:0] idx,
    input msg_t       m
  );
    logic [WORD_W-1:0] w;
    w = '0;
    case (idx)
      3'd0:    w = {2'b0, m.msg_type};
      3'd1:    w = {1'b0, m.block_x};
      3'd2:    w = {3'b0, m.block_y};
      3'd3:    w = m.card;
      3'd4:    w = {3'b0, m.sel_len};
      3'd5:    w = {5'b0, m.move_dir};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/send_all_ack_synchronizer.sv
// Flop chain bringing the peer's asynchronous Ack into clk.
// Ports: clk, rst (async active-low), d (async in), q (synced).
module ack_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= '0;
    else      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/send_all.sv
// Link transmitter: sends one message as six 4-phase handshaked words.
// Ports: ctrl_* fields + en in, Ack_in from peer; Request_out, inter_data_out, busy, done out.
module send_all
  import send_all_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                interboard_rst,
  input  logic                en,
  input  logic [TYPE_W-1:0]   ctrl_msg_type,
  input  logic [X_W-1:0]      ctrl_block_x,
  input  logic [Y_W-1:0]      ctrl_block_y,
  input  logic [CARD_W-1:0]   ctrl_card,
  input  logic [LEN_W-1:0]    ctrl_sel_len,
  input  logic [DIR_W-1:0]    ctrl_move_dir,
  input  logic                Ack_in,
  output logic                Request_out,
  output logic [WORD_W-1:0]   inter_data_out,
  output logic                busy,
  output logic                done
);

  localparam logic [3:0] SC_L = 4'(SETUP_CYCLES);
  localparam logic [2:0] LAST = 3'(NUM_WORDS - 1);

  logic       ack_s;
  logic [2:0] state;
  logic [2:0] idx;
  logic [3:0] cnt;
  msg_t       fields;
  msg_t       in_msg;

  assign in_msg = {ctrl_msg_type, ctrl_block_x, ctrl_block_y,
                   ctrl_card, ctrl_sel_len, ctrl_move_dir};

  ack_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (Ack_in),
    .q  (ack_s)
  );

  // cnt==0 in SETUP means the word is not yet on the pins;
  // loading and counting both wait for a low ack so data
  // never moves while the peer still acknowledges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      cnt            <= '0;
      fields         <= '0;
      Request_out    <= 1'b0;
      inter_data_out <= '0;
    end else if (interboard_rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      cnt            <= '0;
      fields         <= '0;
      Request_out    <= 1'b0;
      inter_data_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            fields <= in_msg;
            idx    <= '0;
            cnt    <= '0;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (!ack_s) begin
            if (cnt == 4'd0) begin
              inter_data_out <= pack_word(idx, fields);
              cnt            <= 4'd1;
            end else if (cnt == SC_L) begin
              Request_out <= 1'b1;
              state       <= S_REQ;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        S_REQ: begin
          if (ack_s) begin
            Request_out <= 1'b0;
            state       <= S_REL;
          end
        end
        S_REL: begin
          if (!ack_s) begin
            if (idx == LAST) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 3'd1;
              cnt   <= '0;
              state <= S_SETUP;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_send_all.sv
// Directed bench for send_all with an 11-cycle-Ack peer model.
// Scenario tasks run in sequence; protocol monitor runs alongside.
module tb_send_all;

  localparam int SC = 2;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       interboard_rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] ctrl_msg_type = '0;
  logic [4:0] ctrl_block_x = '0;
  logic [2:0] ctrl_block_y = '0;
  logic [5:0] ctrl_card = '0;
  logic [2:0] ctrl_sel_len = '0;
  logic       ctrl_move_dir = 1'b0;
  logic       Ack_in;
  logic       Request_out;
  logic [5:0] inter_data_out;
  logic       busy;
  logic       done;

  logic peer_on = 1'b1;
  logic peer_ack = 1'b0;
  logic man_ack = 1'b0;
  logic [5:0] cap_q[$];

  int total = 0;
  int passed = 0;

  assign Ack_in = peer_on ? peer_ack : man_ack;

  always #5 clk = ~clk;

  send_all #(
    .SETUP_CYCLES(SC),
    .SYNC_STAGES (SS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .interboard_rst(interboard_rst),
    .en            (en),
    .ctrl_msg_type (ctrl_msg_type),
    .ctrl_block_x  (ctrl_block_x),
    .ctrl_block_y  (ctrl_block_y),
    .ctrl_card     (ctrl_card),
    .ctrl_sel_len  (ctrl_sel_len),
    .ctrl_move_dir (ctrl_move_dir),
    .Ack_in        (Ack_in),
    .Request_out   (Request_out),
    .inter_data_out(inter_data_out),
    .busy          (busy),
    .done          (done)
  );

  // Peer: on Request, hold Ack 11 cycles, capture on the last one.
  always begin
    @(negedge clk);
    if (peer_on && Request_out && !peer_ack) begin
      peer_ack = 1'b1;
      repeat (10) @(negedge clk);
      cap_q.push_back(inter_data_out);
      @(negedge clk);
      peer_ack = 1'b0;
    end
  end

  // Protocol monitor with its own model of the Ack synchroniser.
  logic [1:0] ack_m = 2'b00;
  logic [5:0] prev_data = '0;
  logic       prev_req = 1'b0;
  logic       prev_acks = 1'b0;
  logic       mon_en = 1'b1;
  int         age = 0;
  int         mon_viol = 0;
  int         mon_rises = 0;

  always @(posedge clk) ack_m <= {ack_m[0], Ack_in};

  always @(negedge clk) begin
    if (inter_data_out != prev_data) age = 0;
    else if (age < 1000) age = age + 1;
    if (mon_en) begin
      if (Request_out && !prev_req && age < SC)
        mon_viol = mon_viol + 1;
      if (inter_data_out != prev_data && (prev_req || prev_acks))
        mon_viol = mon_viol + 1;
    end
    if (Request_out && !prev_req) mon_rises = mon_rises + 1;
    prev_data = inter_data_out;
    prev_req  = Request_out;
    prev_acks = ack_m[1];
  end

  task automatic start_msg(
    input logic [3:0] t, input logic [4:0] x, input logic [2:0] y,
    input logic [5:0] c, input logic [2:0] l, input logic d
  );
    @(negedge clk);
    ctrl_msg_type = t;
    ctrl_block_x  = x;
    ctrl_block_y  = y;
    ctrl_card     = c;
    ctrl_sel_len  = l;
    ctrl_move_dir = d;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    ctrl_msg_type = '0;
    ctrl_block_x  = '0;
    ctrl_block_y  = '0;
    ctrl_card     = '0;
    ctrl_sel_len  = '0;
    ctrl_move_dir = 1'b0;
  endtask

  task automatic wait_done(
    input int lim, output int dn, output int gap, output bit to
  );
    int c;
    c = 0; dn = 0; gap = 0;
    while (dn == 0 && c < lim) begin
      @(negedge clk);
      c++;
      if (done) dn++;
      else if (!busy) gap++;
    end
    to = (dn == 0);
  endtask

  task automatic wait_peer_idle();
    int c;
    c = 0;
    while (peer_ack && c < 100) begin
      @(negedge clk);
      c++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (Request_out !== 1'b0) $display("FAIL reset_req got %b want 0", Request_out);
    else passed++;
    total++;
    if (inter_data_out !== 6'd0) $display("FAIL reset_data got %0d want 0", inter_data_out);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else passed++;
    total++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
    else passed++;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_basic();
    int exp[6] = '{5, 17, 3, 42, 4, 1};
    int dn, gap, extra;
    bit to;
    cap_q.delete();
    start_msg(4'd5, 5'd17, 3'd3, 6'd42, 3'd4, 1'b1);
    total++;
    if (busy !== 1'b1 || Request_out !== 1'b0)
      $display("FAIL basic_accept got busy=%b req=%b want 1 0", busy, Request_out);
    else passed++;
    @(negedge clk);
    total++;
    if (inter_data_out !== 6'd5) $display("FAIL basic_word0 got %0d want 5", inter_data_out);
    else passed++;
    @(negedge clk);
    total++;
    if (Request_out !== 1'b0) $display("FAIL basic_req_early got %b want 0", Request_out);
    else passed++;
    @(negedge clk);
    total++;
    if (Request_out !== 1'b1) $display("FAIL basic_req_rise got %b want 1", Request_out);
    else passed++;
    wait_done(2000, dn, gap, to);
    total++;
    if (to) $display("FAIL basic_timeout got no done want done");
    else passed++;
    total++;
    if (gap !== 0) $display("FAIL basic_busy_gap got %0d want 0", gap);
    else passed++;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL basic_busy_after got %b want 0", busy);
    else passed++;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    total++;
    if (dn + extra !== 1) $display("FAIL basic_done_count got %0d want 1", dn + extra);
    else passed++;
    total++;
    if (cap_q.size() !== 6) $display("FAIL basic_nwords got %0d want 6", cap_q.size());
    else passed++;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= cap_q.size() || cap_q[i] !== 6'(exp[i]))
        $display("FAIL basic_word%0d got %0d want %0d", i,
                 (i < cap_q.size()) ? cap_q[i] : 6'd0, exp[i]);
      else passed++;
    end
    total++;
    if (inter_data_out !== 6'd1) $display("FAIL basic_hold_last got %0d want 1", inter_data_out);
    else passed++;
  endtask

  task automatic test_abort_rst();
    int exp[6] = '{9, 3, 7, 1, 2, 0};
    int c, dn, gap, ndone;
    bit to;
    cap_q.delete();
    start_msg(4'd11, 5'd20, 3'd6, 6'd13, 3'd2, 1'b0);
    c = 0;
    while (!(cap_q.size() == 2 && Request_out) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (c >= 2000) $display("FAIL rst_reach_word2 got timeout want REQ");
    else passed++;
    mon_en = 1'b0;
    #1 rst = 1'b0;
    #1;
    total++;
    if (Request_out !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_async got req=%b busy=%b want 0 0", Request_out, busy);
    else passed++;
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done) ndone++;
    end
    total++;
    if (ndone !== 0) $display("FAIL rst_no_done got %0d want 0", ndone);
    else passed++;
    wait_peer_idle();
    mon_en = 1'b1;
    cap_q.delete();
    start_msg(4'd9, 5'd3, 3'd7, 6'd1, 3'd2, 1'b0);
    wait_done(2000, dn, gap, to);
    total++;
    if (to) $display("FAIL rst_restart_timeout got no done want done");
    else passed++;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= cap_q.size() || cap_q[i] !== 6'(exp[i]))
        $display("FAIL rst_restart_word%0d got %0d want %0d", i,
                 (i < cap_q.size()) ? cap_q[i] : 6'd0, exp[i]);
      else passed++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_abort_ib();
    int c, ndone, nbusy;
    cap_q.delete();
    start_msg(4'd2, 5'd30, 3'd5, 6'd63, 3'd7, 1'b1);
    c = 0;
    while (cap_q.size() < 5 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (c >= 2000) $display("FAIL ib_reach_word4 got timeout want REL");
    else passed++;
    mon_en = 1'b0;
    interboard_rst = 1'b1;
    @(negedge clk);
    interboard_rst = 1'b0;
    total++;
    if (busy !== 1'b0 || Request_out !== 1'b0 || inter_data_out !== 6'd0 || done !== 1'b0)
      $display("FAIL ib_clear got busy=%b req=%b data=%0d done=%b want 0 0 0 0",
               busy, Request_out, inter_data_out, done);
    else passed++;
    ndone = 0;
    nbusy = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    total++;
    if (ndone !== 0 || nbusy !== 0)
      $display("FAIL ib_stays_idle got done=%0d busy=%0d want 0 0", ndone, nbusy);
    else passed++;
    wait_peer_idle();
    mon_en = 1'b1;
  endtask

  task automatic test_en_busy();
    int exp[6] = '{6, 1, 2, 33, 5, 0};
    int c, dn, gap, extra, nbusy;
    bit to;
    cap_q.delete();
    start_msg(4'd6, 5'd1, 3'd2, 6'd33, 3'd5, 1'b0);
    c = 0;
    while (!(cap_q.size() == 3 && Request_out) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (c >= 2000) $display("FAIL busy_reach_word3 got timeout want REQ");
    else passed++;
    start_msg(4'd15, 5'd31, 3'd7, 6'd63, 3'd7, 1'b1);
    wait_done(2000, dn, gap, to);
    total++;
    if (to) $display("FAIL busy_timeout got no done want done");
    else passed++;
    extra = 0;
    nbusy = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) extra++;
      if (busy) nbusy++;
    end
    total++;
    if (dn + extra !== 1) $display("FAIL busy_done_count got %0d want 1", dn + extra);
    else passed++;
    total++;
    if (nbusy !== 0) $display("FAIL busy_en_dropped got %0d busy cycles want 0", nbusy);
    else passed++;
    total++;
    if (cap_q.size() !== 6) $display("FAIL busy_nwords got %0d want 6", cap_q.size());
    else passed++;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= cap_q.size() || cap_q[i] !== 6'(exp[i]))
        $display("FAIL busy_word%0d got %0d want %0d", i,
                 (i < cap_q.size()) ? cap_q[i] : 6'd0, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_stale_ack();
    int exp[6] = '{1, 2, 3, 4, 5, 1};
    int nreq, d, dn, gap;
    bit to;
    cap_q.delete();
    peer_on = 1'b0;
    man_ack = 1'b1;
    repeat (5) @(negedge clk);
    start_msg(4'd1, 5'd2, 3'd3, 6'd4, 3'd5, 1'b1);
    nreq = 0;
    repeat (20) begin
      @(negedge clk);
      if (Request_out) nreq++;
    end
    total++;
    if (nreq !== 0) $display("FAIL stale_req got %0d high cycles want 0", nreq);
    else passed++;
    total++;
    if (busy !== 1'b1) $display("FAIL stale_busy got %b want 1", busy);
    else passed++;
    man_ack = 1'b0;
    d = 0;
    while (!Request_out && d < 50) begin
      @(negedge clk);
      d++;
    end
    total++;
    if (d < SC || d > SS + 1 + SC)
      $display("FAIL stale_release got %0d cycles want %0d..%0d", d, SC, SS + 1 + SC);
    else passed++;
    peer_on = 1'b1;
    wait_done(2000, dn, gap, to);
    total++;
    if (to) $display("FAIL stale_timeout got no done want done");
    else passed++;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= cap_q.size() || cap_q[i] !== 6'(exp[i]))
        $display("FAIL stale_word%0d got %0d want %0d", i,
                 (i < cap_q.size()) ? cap_q[i] : 6'd0, exp[i]);
      else passed++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_protocol();
    total++;
    if (mon_viol !== 0) $display("FAIL proto_violations got %0d want 0", mon_viol);
    else passed++;
    total++;
    if (mon_rises < 24) $display("FAIL proto_req_rises got %0d want >=24", mon_rises);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort_rst();
    test_abort_ib();
    test_en_busy();
    test_stale_ack();
    test_protocol();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
